mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_stage.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MEM stage: memory-op encoding, FSM states and address helpers.
package mips_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Low address bits that are meaningful for an access of this size.
    function automatic logic [1:0] size_mask(input mem_op_e op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'b10;
            OP_LW, OP_SW:         return 2'b00;
            default:              return 2'b11;
        endcase
    endfunction

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] a);
        return (a & ~size_mask(op)) != 2'b00;
    endfunction

    function automatic logic [3:0] byte_enables(input mem_op_e op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: return 4'b0011 << {a[1], 1'b0};
            OP_LW, OP_SW:         return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-side, data-memory and write-back signals of the MEM stage; master is the stage itself.
interface mem_stage_if #(parameter int XLEN = mips_pkg::XLEN_DEFAULT) ();
    import mips_pkg::*;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_alu_out;
    logic [XLEN-1:0] ex_store_data;
    mem_op_e         ex_mem_op;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_data;
    logic            bus_err;

    modport master (
        input  ex_valid, ex_alu_out, ex_store_data, ex_mem_op, ex_rd, ex_reg_write,
        input  dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output wb_valid, wb_rd, wb_reg_write, wb_data, bus_err
    );

    modport slave (
        output ex_valid, ex_alu_out, ex_store_data, ex_mem_op, ex_rd, ex_reg_write,
        output dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  wb_valid, wb_rd, wb_reg_write, wb_data, bus_err
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load lane select and sign/zero extension (little-endian lanes).
module load_align
    import mips_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  mem_op_e         op_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata_i[{addr_i, 3'b000} +: 8];
        halfSel = rdata_i[{addr_i[1], 4'b0000} +: 16];
        data_o  = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{(XLEN-8){byteSel[7]}}, byteSel};
            OP_LBU:  data_o = {{(XLEN-8){1'b0}}, byteSel};
            OP_LH:   data_o = {{(XLEN-16){halfSel[15]}}, halfSel};
            OP_LHU:  data_o = {{(XLEN-16){1'b0}}, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: IDLE/ACCESS bus FSM with ack timeout and one-cycle write-back pulses.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned halves/words instead of masking the low bits.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = XLEN_DEFAULT
) (
    input logic         clk,
    input logic         reset,
    mem_stage_if.master bus
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_exc
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    mem_op_e         op_q, op_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
    logic [3:0]      be_q, be_d;
    logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic            we_q, we_d, rw_q, rw_d;
    logic            wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, bus_err_q, bus_err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] loadData, effAddr, repData;
    logic            req;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
    assign misalign_exc = mis_q;
`endif

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i (bus.dmem_rdata),
        .addr_i  (addr_q[1:0]),
        .op_i    (op_q),
        .data_o  (loadData)
    );

    assign req             = (state_q == ST_ACCESS);
    assign bus.ex_ready    = (state_q == ST_IDLE);
    assign bus.dmem_req    = req;
    assign bus.dmem_we     = req & we_q;
    assign bus.dmem_be     = req ? be_q : 4'b0000;
    assign bus.dmem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign bus.dmem_wdata  = wdata_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_reg_write = wb_rw_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.bus_err     = bus_err_q;

    // Sub-word stores replicate the lane so the byte enables alone pick the target bytes.
    always_comb begin
        effAddr = {bus.ex_alu_out[XLEN-1:2], bus.ex_alu_out[1:0] & size_mask(bus.ex_mem_op)};
        case (bus.ex_mem_op)
            OP_SB:   repData = {(XLEN/8){bus.ex_store_data[7:0]}};
            OP_SH:   repData = {(XLEN/16){bus.ex_store_data[15:0]}};
            default: repData = bus.ex_store_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        bus_err_d  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d      = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.ex_valid) begin
                    if (bus.ex_mem_op == OP_NONE) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.ex_alu_out;
                        wb_rd_d    = bus.ex_rd;
                        wb_rw_d    = bus.ex_reg_write && (bus.ex_rd != 5'd0);
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (misaligned(bus.ex_mem_op, bus.ex_alu_out[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        mis_d      = 1'b1;
                    end
`endif
                    else begin
                        state_d = ST_ACCESS;
                        op_d    = bus.ex_mem_op;
                        addr_d  = effAddr;
                        we_d    = is_store(bus.ex_mem_op);
                        be_d    = byte_enables(bus.ex_mem_op, effAddr[1:0]);
                        wdata_d = repData;
                        rd_d    = bus.ex_rd;
                        rw_d    = bus.ex_reg_write && !is_store(bus.ex_mem_op) && (bus.ex_rd != 5'd0);
                        cnt_d   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (bus.dmem_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q;
                    if (!we_q) wb_data_d = loadData;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            bus_err_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            bus_err_q  <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-backs are queued at issue and popped on wb_valid.
module tb_mem_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if #(.XLEN(32)) bus ();
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_exc;
`endif

    mem_stage #(.TIMEOUT(16), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc (misalign_exc)
`endif
    );

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sbq[$];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw);
        bus.ex_mem_op     = op;
        bus.ex_alu_out    = addr;
        bus.ex_store_data = sdata;
        bus.ex_rd         = rd;
        bus.ex_reg_write  = rw;
        bus.ex_valid      = 1'b1;
        tick();
        bus.ex_valid      = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        compared++;
        if ({bus.ex_ready, bus.wb_valid, bus.wb_reg_write, bus.dmem_req, bus.dmem_we, bus.bus_err}
            !== 6'b100000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags got=%b exp=100000",
                     {bus.ex_ready, bus.wb_valid, bus.wb_reg_write, bus.dmem_req, bus.dmem_we, bus.bus_err});
        end
        compared++;
        if ({bus.dmem_be, bus.wb_rd} !== 9'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_be_rd got be=%b rd=%0d exp 0", bus.dmem_be, bus.wb_rd);
        end
        compared++;
        if ({bus.wb_data, bus.dmem_addr} !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data_addr got data=%h addr=%h exp 0", bus.wb_data, bus.dmem_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_none_back_to_back;
        logic [31:0] alu [4] = '{32'd10, 32'h1234_5678, 32'd7, 32'hFFFF_FFFF};
        logic [4:0]  rd  [4] = '{5'd19, 5'd0, 5'd5, 5'd31};
        logic        rw  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        erw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (bus.ex_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL none_ready[%0d] got=%b exp=1", i, bus.ex_ready);
            end
            bus.ex_mem_op = OP_NONE;
            bus.ex_alu_out = alu[i];
            bus.ex_rd = rd[i];
            bus.ex_reg_write = rw[i];
            bus.ex_valid = 1'b1;
            sbq.push_back('{rd: rd[i], rw: erw[i], err: 1'b0, chk: 1'b1, data: alu[i]});
            tick();
            compared++;
            if (bus.wb_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL none_valid[%0d] got=%b exp=1", i, bus.wb_valid);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                compared++;
                if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.wb_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL none_wb[%0d] got rd=%0d rw=%b data=%h exp rd=%0d rw=%b data=%h",
                             i, bus.wb_rd, bus.wb_reg_write, bus.wb_data, e.rd, e.rw, e.data);
                end
            end
        end
        bus.ex_valid = 1'b0;
        tick();
        compared++;
        if (bus.wb_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL none_idle got=%b exp=0", bus.wb_valid);
        end
    endtask

    task automatic test_loads;
        mem_op_e     op  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB};
        logic [31:0] ad  [6] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h104, 32'h100};
        logic [31:0] rdt [6] = '{32'h80FF_0000, 32'h1234_8756, 32'h8001_7FFF, 32'h1234_F00D,
                                 32'hCAFE_BABE, 32'h0000_007F};
        logic [31:0] exd [6] = '{32'hFFFF_FF80, 32'h0000_0087, 32'hFFFF_8001, 32'h0000_F00D,
                                 32'hCAFE_BABE, 32'h0000_007F};
        logic [3:0]  exb [6] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b0001};
        logic [31:0] exa [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h100};
        int          dly [6] = '{0, 2, 1, 0, 3, 0};
        logic [4:0]  rd  [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd0};
        logic        erw [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        held;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sbq.push_back('{rd: rd[i], rw: erw[i], err: 1'b0, chk: 1'b1, data: exd[i]});
            issue(op[i], ad[i], $urandom, rd[i], 1'b1);
            compared++;
            if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr} !== {1'b1, 1'b0, exb[i], exa[i]}) begin
                mismatched++;
                $display("[TB] FAIL load_bus[%0d] got req=%b we=%b be=%b addr=%h exp req=1 we=0 be=%b addr=%h",
                         i, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, exb[i], exa[i]);
            end
            held = 1'b1;
            for (int d = 0; d < dly[i]; d++) begin
                tick();
                held &= bus.dmem_req && (bus.dmem_addr === exa[i]);
            end
            compared++;
            if (held !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL load_held[%0d] got=%b exp=1", i, held);
            end
            bus.dmem_ack = 1'b1;
            bus.dmem_rdata = rdt[i];
            tick();
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = $urandom;
            compared++;
            if (bus.wb_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL load_valid[%0d] got=%b exp=1", i, bus.wb_valid);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                compared++;
                if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.bus_err !== e.err ||
                    bus.wb_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL load_wb[%0d] got rd=%0d rw=%b err=%b data=%h exp rd=%0d rw=%b err=%b data=%h",
                             i, bus.wb_rd, bus.wb_reg_write, bus.bus_err, bus.wb_data,
                             e.rd, e.rw, e.err, e.data);
                end
            end
        end
    endtask

    task automatic test_stores;
        mem_op_e     op  [3] = '{OP_SB, OP_SH, OP_SW};
        logic [31:0] ad  [3] = '{32'h201, 32'h202, 32'h204};
        logic [31:0] sd  [3] = '{32'h5566_77AB, 32'h9999_1234, 32'hDEAD_BEEF};
        logic [31:0] exw [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
        logic [3:0]  exb [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] exa [3] = '{32'h200, 32'h200, 32'h204};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{rd: 5'd9, rw: 1'b0, err: 1'b0, chk: 1'b0, data: 32'd0});
            issue(op[i], ad[i], sd[i], 5'd9, 1'b1);
            compared++;
            if ({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata}
                !== {1'b1, 1'b1, exb[i], exa[i], exw[i]}) begin
                mismatched++;
                $display("[TB] FAIL store_bus[%0d] got req=%b we=%b be=%b addr=%h wdata=%h exp req=1 we=1 be=%b addr=%h wdata=%h",
                         i, bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata,
                         exb[i], exa[i], exw[i]);
            end
            bus.dmem_ack = 1'b1;
            tick();
            bus.dmem_ack = 1'b0;
            compared++;
            if (bus.wb_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL store_valid[%0d] got=%b exp=1", i, bus.wb_valid);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                compared++;
                if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.bus_err !== e.err) begin
                    mismatched++;
                    $display("[TB] FAIL store_wb[%0d] got rd=%0d rw=%b err=%b exp rd=%0d rw=%b err=%b",
                             i, bus.wb_rd, bus.wb_reg_write, bus.bus_err, e.rd, e.rw, e.err);
                end
            end
        end
    endtask

    task automatic test_timeout;
        logic held;
        exp_t e;
        sbq.push_back('{rd: 5'd8, rw: 1'b0, err: 1'b1, chk: 1'b0, data: 32'd0});
        issue(OP_LW, 32'h300, 32'd0, 5'd8, 1'b1);
        held = bus.dmem_req;
        for (int c = 1; c < 16; c++) begin
            tick();
            held &= bus.dmem_req;
        end
        compared++;
        if (held !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL to_req_held got=%b exp=1", held);
        end
        tick();
        compared++;
        if ({bus.dmem_req, bus.ex_ready, bus.wb_valid, bus.bus_err} !== 4'b0111) begin
            mismatched++;
            $display("[TB] FAIL to_fire got req=%b ready=%b valid=%b err=%b exp 0111",
                     bus.dmem_req, bus.ex_ready, bus.wb_valid, bus.bus_err);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            compared++;
            if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.bus_err !== e.err) begin
                mismatched++;
                $display("[TB] FAIL to_wb got rd=%0d rw=%b err=%b exp rd=%0d rw=%b err=%b",
                         bus.wb_rd, bus.wb_reg_write, bus.bus_err, e.rd, e.rw, e.err);
            end
        end
        tick();
        compared++;
        if ({bus.bus_err, bus.wb_valid} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL to_pulse got err=%b valid=%b exp 00", bus.bus_err, bus.wb_valid);
        end
    endtask

    task automatic test_ack_at_timeout;
        exp_t e;
        sbq.push_back('{rd: 5'd12, rw: 1'b1, err: 1'b0, chk: 1'b1, data: 32'h600D_CAFE});
        issue(OP_LW, 32'h308, 32'd0, 5'd12, 1'b1);
        repeat (15) tick();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h600D_CAFE;
        tick();
        bus.dmem_ack = 1'b0;
        compared++;
        if (bus.wb_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ackto_valid got=%b exp=1", bus.wb_valid);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            compared++;
            if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.bus_err !== e.err ||
                bus.wb_data !== e.data) begin
                mismatched++;
                $display("[TB] FAIL ackto_wb got rd=%0d rw=%b err=%b data=%h exp rd=%0d rw=%b err=%b data=%h",
                         bus.wb_rd, bus.wb_reg_write, bus.bus_err, bus.wb_data, e.rd, e.rw, e.err, e.data);
            end
        end
    endtask

    task automatic test_reset_in_access;
        logic anyValid;
        issue(OP_LW, 32'h40, 32'd0, 5'd2, 1'b1);
        compared++;
        if (bus.dmem_req !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_acc_req_pre got=%b exp=1", bus.dmem_req);
        end
        reset = 1'b1;
        tick();
        compared++;
        if ({bus.dmem_req, bus.wb_valid} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL rst_acc_drop got req=%b valid=%b exp 00", bus.dmem_req, bus.wb_valid);
        end
        reset = 1'b0;
        anyValid = 1'b0;
        repeat (3) begin
            tick();
            anyValid |= bus.wb_valid;
        end
        compared++;
        if (anyValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_acc_no_wb got=%b exp=0", anyValid);
        end
    endtask

    task automatic test_misalign;
        exp_t e;
`ifdef MEM_MISALIGN_TRAP_EN
        sbq.push_back('{rd: 5'd4, rw: 1'b0, err: 1'b0, chk: 1'b0, data: 32'd0});
        issue(OP_LW, 32'h41, 32'd0, 5'd4, 1'b1);
        compared++;
        if ({misalign_exc, bus.dmem_req, bus.wb_valid} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL mis_trap got exc=%b req=%b valid=%b exp 101",
                     misalign_exc, bus.dmem_req, bus.wb_valid);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            compared++;
            if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.bus_err !== e.err) begin
                mismatched++;
                $display("[TB] FAIL mis_wb got rd=%0d rw=%b err=%b exp rd=%0d rw=%b err=%b",
                         bus.wb_rd, bus.wb_reg_write, bus.bus_err, e.rd, e.rw, e.err);
            end
        end
        tick();
        compared++;
        if ({misalign_exc, bus.dmem_req} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL mis_pulse got exc=%b req=%b exp 00", misalign_exc, bus.dmem_req);
        end
`else
        sbq.push_back('{rd: 5'd4, rw: 1'b1, err: 1'b0, chk: 1'b1, data: 32'hFFFF_ABCD});
        issue(OP_LH, 32'h103, 32'd0, 5'd4, 1'b1);
        compared++;
        if ({bus.dmem_req, bus.dmem_be, bus.dmem_addr} !== {1'b1, 4'b1100, 32'h100}) begin
            mismatched++;
            $display("[TB] FAIL mis_mask_bus got req=%b be=%b addr=%h exp req=1 be=1100 addr=100",
                     bus.dmem_req, bus.dmem_be, bus.dmem_addr);
        end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hABCD_0000;
        tick();
        bus.dmem_ack = 1'b0;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            compared++;
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw ||
                bus.wb_data !== e.data) begin
                mismatched++;
                $display("[TB] FAIL mis_mask_wb got valid=%b rd=%0d rw=%b data=%h exp valid=1 rd=%0d rw=%b data=%h",
                         bus.wb_valid, bus.wb_rd, bus.wb_reg_write, bus.wb_data, e.rd, e.rw, e.data);
            end
        end
`endif
    endtask

    task automatic test_back_to_back;
        exp_t e;
        sbq.push_back('{rd: 5'd10, rw: 1'b1, err: 1'b0, chk: 1'b1, data: 32'h0BAD_F00D});
        issue(OP_LW, 32'h80, 32'd0, 5'd10, 1'b1);
        bus.ex_mem_op = OP_NONE;
        bus.ex_alu_out = 32'h55;
        bus.ex_rd = 5'd11;
        bus.ex_reg_write = 1'b1;
        bus.ex_valid = 1'b1;
        sbq.push_back('{rd: 5'd11, rw: 1'b1, err: 1'b0, chk: 1'b1, data: 32'h55});
        compared++;
        if (bus.ex_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_busy got=%b exp=0", bus.ex_ready);
        end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0BAD_F00D;
        tick();
        bus.dmem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) bus.ex_valid = 1'b0;
            compared++;
            if (bus.wb_valid !== 1'b1 || sbq.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL b2b_valid[%0d] got=%b exp=1 (queued=%0d)", k, bus.wb_valid, sbq.size());
            end else begin
                e = sbq.pop_front();
                compared++;
                if (bus.wb_rd !== e.rd || bus.wb_reg_write !== e.rw || bus.wb_data !== e.data) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_wb[%0d] got rd=%0d rw=%b data=%h exp rd=%0d rw=%b data=%h",
                             k, bus.wb_rd, bus.wb_reg_write, bus.wb_data, e.rd, e.rw, e.data);
                end
            end
            tick();
        end
        compared++;
        if (bus.wb_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_single got=%b exp=0", bus.wb_valid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.ex_valid = 1'b0;
        bus.ex_alu_out = '0;
        bus.ex_store_data = '0;
        bus.ex_mem_op = OP_NONE;
        bus.ex_rd = '0;
        bus.ex_reg_write = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        test_reset();
        test_none_back_to_back();
        test_loads();
        test_stores();
        test_timeout();
        test_ack_at_timeout();
        test_reset_in_access();
        test_misalign();
        test_back_to_back();
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL sb_drain got=%0d exp=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
